ysyx_22040386_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core: the producer of the `load_use_flag` / `jump_flag` bubble and flush controls that the ID/EX register consumes, plus the stall enables for PC, IF/ID, ID/EX and EX/MEM. It detects load-use hazards between ID and EX and applies EX-resolved control-flow redirects. It freezes the pipeline while the data-memory port is busy, and holds any redirect that arrives during a freeze until the freeze ends. Saturating event counters are provided for simulation statistics.

---
 rtl/ysyx_22040386_hazard_ctrl_if.sv | 47 ++++
 rtl/ysyx_22040386_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_ysyx_22040386_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM pipeline status in, stall/flush controls out.
// The pipeline side drives through "master"; the hazard controller sits on "slave".
interface ysyx_22040386_hazard_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             i_HAZARD_id_valid;
  logic [4:0]       i_HAZARD_id_rs1_addr;
  logic [4:0]       i_HAZARD_id_rs2_addr;
  logic             i_HAZARD_id_rs1_used;
  logic             i_HAZARD_id_rs2_used;
  logic             i_HAZARD_ex_MemRead;
  logic [4:0]       i_HAZARD_ex_reg_wr_addr;
  logic             i_HAZARD_ex_redirect;
  logic [XLEN-1:0]  i_HAZARD_ex_target;
  logic             i_HAZARD_mem_busy;

  logic             o_HAZARD_load_use_flag;
  logic             o_HAZARD_jump_flag;
  logic [XLEN-1:0]  o_HAZARD_redirect_pc;
  logic             o_HAZARD_pc_stall;
  logic             o_HAZARD_if_id_stall;
  logic             o_HAZARD_id_ex_stall;
  logic             o_HAZARD_ex_mem_stall;
  logic [CNT_W-1:0] o_HAZARD_stall_cnt;
  logic [CNT_W-1:0] o_HAZARD_flush_cnt;

  modport master (
    output i_HAZARD_id_valid, i_HAZARD_id_rs1_addr, i_HAZARD_id_rs2_addr,
           i_HAZARD_id_rs1_used, i_HAZARD_id_rs2_used, i_HAZARD_ex_MemRead,
           i_HAZARD_ex_reg_wr_addr, i_HAZARD_ex_redirect, i_HAZARD_ex_target,
           i_HAZARD_mem_busy,
    input  o_HAZARD_load_use_flag, o_HAZARD_jump_flag, o_HAZARD_redirect_pc,
           o_HAZARD_pc_stall, o_HAZARD_if_id_stall, o_HAZARD_id_ex_stall,
           o_HAZARD_ex_mem_stall, o_HAZARD_stall_cnt, o_HAZARD_flush_cnt
  );

  modport slave (
    input  i_HAZARD_id_valid, i_HAZARD_id_rs1_addr, i_HAZARD_id_rs2_addr,
           i_HAZARD_id_rs1_used, i_HAZARD_id_rs2_used, i_HAZARD_ex_MemRead,
           i_HAZARD_ex_reg_wr_addr, i_HAZARD_ex_redirect, i_HAZARD_ex_target,
           i_HAZARD_mem_busy,
    output o_HAZARD_load_use_flag, o_HAZARD_jump_flag, o_HAZARD_redirect_pc,
           o_HAZARD_pc_stall, o_HAZARD_if_id_stall, o_HAZARD_id_ex_stall,
           o_HAZARD_ex_mem_stall, o_HAZARD_stall_cnt, o_HAZARD_flush_cnt
  );
endinterface

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirects, memory-busy freeze
// with a one-entry pending redirect, and saturating stall/flush statistics.
module ysyx_22040386_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic                          i_HAZARD_clk,
  input logic                          i_HAZARD_rst,
  ysyx_22040386_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FREEZE      = 2'd1,
    FREEZE_PEND = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  pend_target;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic             lu_hit;
  logic             pend_exit;
  logic             load_use_flag;
  logic             jump_flag;
  logic [XLEN-1:0]  redirect_pc;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_mem_stall;

  // Same-cycle hazard decode; priority is freeze > pending exit > live jump > load-use.
  // A FREEZE state with memory already idle behaves like RUN, so live redirects and
  // load-use re-evaluate on the release cycle. Outputs are forced to 0 in reset.
  always_comb begin
    lu_hit = hz.i_HAZARD_id_valid & hz.i_HAZARD_ex_MemRead &
             (hz.i_HAZARD_ex_reg_wr_addr != 5'd0) &
             ((hz.i_HAZARD_id_rs1_used & (hz.i_HAZARD_id_rs1_addr == hz.i_HAZARD_ex_reg_wr_addr)) |
              (hz.i_HAZARD_id_rs2_used & (hz.i_HAZARD_id_rs2_addr == hz.i_HAZARD_ex_reg_wr_addr)));
    pend_exit     = (state == FREEZE_PEND) & ~hz.i_HAZARD_mem_busy;
    load_use_flag = 1'b0;
    jump_flag     = 1'b0;
    redirect_pc   = hz.i_HAZARD_ex_target;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if (i_HAZARD_rst) begin
      redirect_pc = '0;
    end else if (hz.i_HAZARD_mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (pend_exit) begin
      jump_flag   = 1'b1;
      redirect_pc = pend_target;
    end else if (hz.i_HAZARD_ex_redirect) begin
      jump_flag = 1'b1;
    end else if (lu_hit) begin
      load_use_flag = 1'b1;
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
    end
  end

  // Freeze FSM, first-wins redirect latch and saturating statistics counters.
  always_ff @(posedge i_HAZARD_clk or posedge i_HAZARD_rst) begin
    if (i_HAZARD_rst) begin
      state       <= RUN;
      pend_target <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      case (state)
        RUN, FREEZE: begin
          if (hz.i_HAZARD_mem_busy && hz.i_HAZARD_ex_redirect) begin
            state       <= FREEZE_PEND;
            pend_target <= hz.i_HAZARD_ex_target;
          end else if (hz.i_HAZARD_mem_busy) begin
            state <= FREEZE;
          end else begin
            state <= RUN;
          end
        end
        FREEZE_PEND: begin
          if (!hz.i_HAZARD_mem_busy) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (jump_flag && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.o_HAZARD_load_use_flag = load_use_flag;
  assign hz.o_HAZARD_jump_flag     = jump_flag;
  assign hz.o_HAZARD_redirect_pc   = redirect_pc;
  assign hz.o_HAZARD_pc_stall      = pc_stall;
  assign hz.o_HAZARD_if_id_stall   = if_id_stall;
  assign hz.o_HAZARD_id_ex_stall   = id_ex_stall;
  assign hz.o_HAZARD_ex_mem_stall  = ex_mem_stall;
  assign hz.o_HAZARD_stall_cnt     = stall_cnt;
  assign hz.o_HAZARD_flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Directed bench for the hazard controller. A second instance with 4-bit counters
// shares the same stimulus so counter saturation can be observed.
module tb_ysyx_22040386_hazard_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ysyx_22040386_hazard_ctrl_if #(.XLEN(64), .CNT_W(32)) hz ();
  ysyx_22040386_hazard_ctrl_if #(.XLEN(64), .CNT_W(4))  hz_sat ();

  ysyx_22040386_hazard_ctrl #(.XLEN(64), .CNT_W(32)) dut (
    .i_HAZARD_clk (clk),
    .i_HAZARD_rst (rst),
    .hz           (hz.slave)
  );

  ysyx_22040386_hazard_ctrl #(.XLEN(64), .CNT_W(4)) dut_sat (
    .i_HAZARD_clk (clk),
    .i_HAZARD_rst (rst),
    .hz           (hz_sat.slave)
  );

  assign hz_sat.i_HAZARD_id_valid       = hz.i_HAZARD_id_valid;
  assign hz_sat.i_HAZARD_id_rs1_addr    = hz.i_HAZARD_id_rs1_addr;
  assign hz_sat.i_HAZARD_id_rs2_addr    = hz.i_HAZARD_id_rs2_addr;
  assign hz_sat.i_HAZARD_id_rs1_used    = hz.i_HAZARD_id_rs1_used;
  assign hz_sat.i_HAZARD_id_rs2_used    = hz.i_HAZARD_id_rs2_used;
  assign hz_sat.i_HAZARD_ex_MemRead     = hz.i_HAZARD_ex_MemRead;
  assign hz_sat.i_HAZARD_ex_reg_wr_addr = hz.i_HAZARD_ex_reg_wr_addr;
  assign hz_sat.i_HAZARD_ex_redirect    = hz.i_HAZARD_ex_redirect;
  assign hz_sat.i_HAZARD_ex_target      = hz.i_HAZARD_ex_target;
  assign hz_sat.i_HAZARD_mem_busy       = hz.i_HAZARD_mem_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs just after a rising edge, then waits for the falling edge.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rs1u, input logic rs2u, input logic memrd,
                               input logic [4:0] wr, input logic redir,
                               input logic [63:0] tgt, input logic busy);
    hz.i_HAZARD_id_valid       = v;
    hz.i_HAZARD_id_rs1_addr    = rs1;
    hz.i_HAZARD_id_rs2_addr    = rs2;
    hz.i_HAZARD_id_rs1_used    = rs1u;
    hz.i_HAZARD_id_rs2_used    = rs2u;
    hz.i_HAZARD_ex_MemRead     = memrd;
    hz.i_HAZARD_ex_reg_wr_addr = wr;
    hz.i_HAZARD_ex_redirect    = redir;
    hz.i_HAZARD_ex_target      = tgt;
    hz.i_HAZARD_mem_busy       = busy;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic lu, input logic jf, input logic pcs,
                            input logic ifid, input logic idex, input logic exmem);
    checkOutput({tag, "_lu"},    64'(hz.o_HAZARD_load_use_flag), 64'(lu));
    checkOutput({tag, "_jump"},  64'(hz.o_HAZARD_jump_flag),     64'(jf));
    checkOutput({tag, "_pcst"},  64'(hz.o_HAZARD_pc_stall),      64'(pcs));
    checkOutput({tag, "_ifid"},  64'(hz.o_HAZARD_if_id_stall),   64'(ifid));
    checkOutput({tag, "_idex"},  64'(hz.o_HAZARD_id_ex_stall),   64'(idex));
    checkOutput({tag, "_exmem"}, 64'(hz.o_HAZARD_ex_mem_stall),  64'(exmem));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    hz.i_HAZARD_id_valid       = 1'b0;
    hz.i_HAZARD_id_rs1_addr    = 5'd0;
    hz.i_HAZARD_id_rs2_addr    = 5'd0;
    hz.i_HAZARD_id_rs1_used    = 1'b0;
    hz.i_HAZARD_id_rs2_used    = 1'b0;
    hz.i_HAZARD_ex_MemRead     = 1'b0;
    hz.i_HAZARD_ex_reg_wr_addr = 5'd0;
    hz.i_HAZARD_ex_redirect    = 1'b0;
    hz.i_HAZARD_ex_target      = 64'h0;
    hz.i_HAZARD_mem_busy       = 1'b0;

    // Power-on reset state
    #3;
    checkFlags("por", 0, 0, 0, 0, 0, 0);
    checkOutput("por_rpc",   hz.o_HAZARD_redirect_pc, 64'h0);
    checkOutput("por_scnt",  64'(hz.o_HAZARD_stall_cnt), 64'd0);
    checkOutput("por_fcnt",  64'(hz.o_HAZARD_flush_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    advance();

    // Load-use on rs2
    applyStimulus(1, 5'd0, 5'd5, 0, 1, 1, 5'd5, 0, 64'h0, 0);
    checkFlags("lu_rs2", 1, 0, 1, 1, 0, 0);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 0);
    checkFlags("lu_after", 0, 0, 0, 0, 0, 0);
    checkOutput("lu_scnt", 64'(hz.o_HAZARD_stall_cnt), 64'd1);
    advance();
    // Destination x0 never hazards
    applyStimulus(1, 5'd0, 5'd0, 0, 1, 1, 5'd0, 0, 64'h0, 0);
    checkFlags("lu_x0", 0, 0, 0, 0, 0, 0);
    advance();
    // Source not actually read
    applyStimulus(1, 5'd0, 5'd5, 0, 0, 1, 5'd5, 0, 64'h0, 0);
    checkFlags("lu_unused", 0, 0, 0, 0, 0, 0);
    advance();
    // ID bubble
    applyStimulus(0, 5'd5, 5'd5, 1, 1, 1, 5'd5, 0, 64'h0, 0);
    checkFlags("lu_novalid", 0, 0, 0, 0, 0, 0);
    advance();
    // Load-use on rs1
    applyStimulus(1, 5'd7, 5'd3, 1, 1, 1, 5'd7, 0, 64'h0, 0);
    checkFlags("lu_rs1", 1, 0, 1, 1, 0, 0);
    advance();

    // Redirect overrides load-use
    applyStimulus(1, 5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 64'h80000040, 0);
    checkFlags("jmp", 0, 1, 0, 0, 0, 0);
    checkOutput("jmp_rpc", hz.o_HAZARD_redirect_pc, 64'h80000040);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 0);
    checkFlags("jmp_after", 0, 0, 0, 0, 0, 0);
    checkOutput("jmp_fcnt", 64'(hz.o_HAZARD_flush_cnt), 64'd1);
    checkOutput("jmp_scnt", 64'(hz.o_HAZARD_stall_cnt), 64'd2);
    advance();

    // Freeze with two redirects arriving; the first one must win
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 1);
    checkFlags("frz1", 0, 0, 1, 1, 1, 1);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 64'h80000100, 1);
    checkFlags("frz2", 0, 0, 1, 1, 1, 1);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 64'h80000200, 1);
    checkFlags("frz3", 0, 0, 1, 1, 1, 1);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h12345678, 1);
    checkFlags("frz4", 0, 0, 1, 1, 1, 1);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h999, 0);
    checkFlags("frz_exit", 0, 1, 0, 0, 0, 0);
    checkOutput("frz_exit_rpc", hz.o_HAZARD_redirect_pc, 64'h80000100);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h999, 0);
    checkFlags("frz_post", 0, 0, 0, 0, 0, 0);
    checkOutput("frz_post_rpc", hz.o_HAZARD_redirect_pc, 64'h999);
    checkOutput("frz_scnt", 64'(hz.o_HAZARD_stall_cnt), 64'd6);
    checkOutput("frz_fcnt", 64'(hz.o_HAZARD_flush_cnt), 64'd2);
    advance();

    // Freeze masks load-use; load-use re-appears once memory is idle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 64'h0, 1);
      checkFlags($sformatf("frzlu%0d", i), 0, 0, 1, 1, 1, 1);
      advance();
    end
    applyStimulus(1, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 64'h0, 0);
    checkFlags("frzlu_rel", 1, 0, 1, 1, 0, 0);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 0);
    checkOutput("frzlu_scnt", 64'(hz.o_HAZARD_stall_cnt), 64'd10);
    checkOutput("frzlu_sat_scnt", 64'(hz_sat.o_HAZARD_stall_cnt), 64'd10);
    advance();

    // Reset asserted mid-cycle while a redirect is pending
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 64'h80000300, 1);
    checkFlags("rstp_busy", 0, 0, 1, 1, 1, 1);
    advance();
    hz.i_HAZARD_ex_redirect = 1'b0;
    hz.i_HAZARD_ex_target   = 64'habc;
    #2;
    rst = 1'b1;
    #1;
    checkFlags("rst_mid", 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_rpc",  hz.o_HAZARD_redirect_pc, 64'h0);
    checkOutput("rst_mid_scnt", 64'(hz.o_HAZARD_stall_cnt), 64'd0);
    checkOutput("rst_mid_fcnt", 64'(hz.o_HAZARD_flush_cnt), 64'd0);
    advance();
    hz.i_HAZARD_mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkFlags("rst_rel", 0, 0, 0, 0, 0, 0);
    checkOutput("rst_rel_rpc", hz.o_HAZARD_redirect_pc, 64'habc);
    advance();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 0);
    checkFlags("rst_rel2", 0, 0, 0, 0, 0, 0);
    checkOutput("rst_rel_fcnt", 64'(hz.o_HAZARD_flush_cnt), 64'd0);
    advance();

    // Back-to-back load-use for 20 cycles; 4-bit counter must stop at 15
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5'd0, 5'd12, 0, 1, 1, 5'd12, 0, 64'h0, 0);
      checkOutput($sformatf("sat_lu%0d", i), 64'(hz.o_HAZARD_load_use_flag), 64'd1);
      advance();
    end
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 64'h0, 0);
    checkOutput("sat_scnt4",  64'(hz_sat.o_HAZARD_stall_cnt), 64'd15);
    checkOutput("sat_scnt32", 64'(hz.o_HAZARD_stall_cnt), 64'd20);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
